// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_arb_pkg;

  // Lifecycle of one peripheral request.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    ISSUED = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating event-counter pair: peripheral grants and peripheral stall cycles.
// Latency: counts are visible the cycle after the event.
// Backpressure: none; counters saturate at all-ones instead of wrapping.
//
// Ports: clock, reset (sync, active-high), inc_grant / inc_stall event strobes,
//        stat_grants / stat_stall_cycles counter outputs.
module dmem_arb_stats
  import dmem_arb_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_grant,
  input  logic             inc_stall,
  output logic [CNT_W-1:0] stat_grants,
  output logic [CNT_W-1:0] stat_stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_grants       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (inc_grant && (stat_grants != CNT_MAX))
        stat_grants <= stat_grants + 1'b1;
      if (inc_stall && (stat_stall_cycles != CNT_MAX))
        stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU (fixed priority, never stalled) and one peripheral.
// Latency: peripheral accept -> rsp_valid in 2 cycles minimum; CPU path is a direct RAM connection.
// Backpressure: p_req_ready only in IDLE (max 1 request per 3 cycles); starvation flagged, never forced.
//
// Ports: clock/reset (sync, active-high); cpu_access/cpu_wren/cpu_addr/cpu_wdata/cpu_q CPU side;
//        p_req_* valid/ready request channel, p_rsp_valid/p_rsp_data one-cycle response, starve flag;
//        ram_wen/ram_addr/ram_din/ram_dout RAM side.
// Build option DMEM_ARB_STATS_EN adds stat_grants and stat_stall_cycles outputs.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 1024,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_access,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_q,
  input  logic              p_req_valid,
  output logic              p_req_ready,
  input  logic              p_req_we,
  input  logic [ADDR_W-1:0] p_req_addr,
  input  logic [DATA_W-1:0] p_req_wdata,
  output logic              p_rsp_valid,
  output logic [DATA_W-1:0] p_rsp_data,
  output logic              starve,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
`ifdef DMEM_ARB_STATS_EN
  output logic [CNT_W-1:0]  stat_grants,
  output logic [CNT_W-1:0]  stat_stall_cycles,
`endif
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

  arb_state_t        state;
  logic              held_we;
  logic [ADDR_W-1:0] held_addr;
  logic [DATA_W-1:0] held_wdata;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_nxt;
  logic              slot_free;
  logic              issue;

  assign slot_free = !cpu_access && !cpu_wren;
  // Gated by reset so a request caught by reset in PEND never touches the RAM.
  assign issue     = (state == PEND) && slot_free && !reset;
  assign wait_nxt  = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      p_req_ready <= 1'b1;
      p_rsp_valid <= 1'b0;
      starve      <= 1'b0;
      wait_cnt    <= '0;
      held_we     <= 1'b0;
      held_addr   <= '0;
      held_wdata  <= '0;
    end else begin
      p_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (p_req_valid && p_req_ready) begin
            held_we     <= p_req_we;
            held_addr   <= p_req_addr;
            held_wdata  <= p_req_wdata;
            wait_cnt    <= '0;
            p_req_ready <= 1'b0;
            state       <= PEND;
          end
        end
        PEND: begin
          if (slot_free) begin
            p_rsp_valid <= 1'b1;
            state       <= ISSUED;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt >= LIMIT)
              starve <= 1'b1;
          end
        end
        ISSUED: begin
          p_req_ready <= 1'b1;
          starve      <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          p_req_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Read data arrives from the RAM in the ISSUED cycle, so it is passed straight through.
  assign p_rsp_data = ((state == ISSUED) && !held_we) ? ram_dout : '0;

  assign ram_addr = issue ? held_addr  : cpu_addr;
  assign ram_din  = issue ? held_wdata : cpu_wdata;
  assign ram_wen  = cpu_wren || (issue && held_we);
  assign cpu_q    = ram_dout;

`ifdef DMEM_ARB_STATS_EN
  logic stall;
  assign stall = (state == PEND) && !slot_free && !reset;

  dmem_arb_stats #(.CNT_W(CNT_W)) u_stats (
    .clock             (clock),
    .reset             (reset),
    .inc_grant         (issue),
    .inc_stall         (stall),
    .stat_grants       (stat_grants),
    .stat_stall_cycles (stat_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LIM = 8;
  localparam int CW  = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_access = 1'b0, cpu_wren = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, cpu_q;
  logic          p_req_valid = 1'b0, p_req_ready, p_req_we = 1'b0;
  logic [AW-1:0] p_req_addr = '0;
  logic [DW-1:0] p_req_wdata = '0;
  logic          p_rsp_valid, starve, ram_wen;
  logic [DW-1:0] p_rsp_data, ram_din;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;
`ifdef DMEM_ARB_STATS_EN
  logic [CW-1:0] stat_grants, stat_stall_cycles;
`endif

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .cpu_access(cpu_access), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_q(cpu_q),
    .p_req_valid(p_req_valid), .p_req_ready(p_req_ready), .p_req_we(p_req_we),
    .p_req_addr(p_req_addr), .p_req_wdata(p_req_wdata),
    .p_rsp_valid(p_rsp_valid), .p_rsp_data(p_rsp_data), .starve(starve),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
`ifdef DMEM_ARB_STATS_EN
    .stat_grants(stat_grants), .stat_stall_cycles(stat_stall_cycles),
`endif
    .ram_dout(ram_dout)
  );

  // Single-port RAM with registered read data.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (ram_wen) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Reference: memory contents as the system should see them, plus the request lifecycle.
  typedef struct { int cyc; logic [DW-1:0] data; } exp_t;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  exp_t rsp_q[$];
  exp_t cpu_exp_q[$];
  int   cyc = 0, errors = 0, checks = 0;
  bit   chk_en = 0;
  bit   outstanding = 0, waiting = 0, accepted = 0;
  int   rsp_cyc = -1, waits = 0, m_grants = 0, m_stalls = 0;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  bit   exp_ready = 1, exp_starve = 0, starve_flag = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, advance the reference.
  task automatic step(input bit rst, input bit acc, input bit we, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cd, input bit pv, input bit pwe,
                      input logic [AW-1:0] pa, input logic [DW-1:0] pd);
    @(posedge clock); #1;
    cyc++;
    reset = rst; cpu_access = acc; cpu_wren = we; cpu_addr = ca; cpu_wdata = cd;
    p_req_valid = pv; p_req_we = pwe; p_req_addr = pa; p_req_wdata = pd;
    exp_ready  = !outstanding;
    exp_starve = starve_flag;
    accepted   = 0;
    if (rst) begin
      outstanding = 0; waiting = 0; starve_flag = 0; rsp_cyc = -1;
      rsp_q.delete(); m_grants = 0; m_stalls = 0;
    end else if (outstanding && !waiting) begin
      if (cyc == rsp_cyc) begin outstanding = 0; starve_flag = 0; end
    end else if (waiting) begin
      if (!acc && !we) begin
        // CPU leaves the RAM alone this cycle: the request takes it.
        rsp_q.push_back('{cyc + 1, r_we ? {DW{1'b0}} : ref_mem[r_addr]});
        if (r_we) ref_mem[r_addr] = r_wdata;
        waiting = 0; rsp_cyc = cyc + 1; m_grants++;
      end else begin
        waits++; m_stalls++;
        if (waits >= LIM) starve_flag = 1;
      end
    end else if (pv) begin
      outstanding = 1; waiting = 1; waits = 0; accepted = 1;
      r_we = pwe; r_addr = pa; r_wdata = pd;
    end
    if (acc) cpu_exp_q.push_back('{cyc + 1, ref_mem[ca]});
    if (we)  ref_mem[ca] = cd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Scoreboard monitor: compares whenever the DUT presents something, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (chk_en) begin
        chk("p_req_ready", {63'd0, p_req_ready}, {63'd0, exp_ready});
        chk("starve", {63'd0, starve}, {63'd0, exp_starve});
        if (p_rsp_valid) begin
          if (rsp_q.size() == 0) chk("rsp_spurious", 64'd1, 64'd0);
          else begin
            e = rsp_q.pop_front();
            chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
            chk("rsp_data", {32'd0, p_rsp_data}, {32'd0, e.data});
          end
        end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
          e = rsp_q.pop_front();
          chk("rsp_missing", 64'd0, 64'd1);
        end
        if (cpu_exp_q.size() > 0 && cpu_exp_q[0].cyc <= cyc) begin
          e = cpu_exp_q.pop_front();
          chk("cpu_q", {32'd0, cpu_q}, {32'd0, e.data});
        end
      end
    end
  end

  initial begin
    bit            have;
    bit            hwe;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    int            r;
    for (int i = 0; i < (1 << AW); i++) begin mem[i] = '0; ref_mem[i] = '0; end

    step(1, 0, 0, '0, '0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0);
    chk_en = 1;
    @(negedge clock);
    chk("reset_rsp_valid", {63'd0, p_rsp_valid}, 64'd0);

    // Read with the CPU idle: minimum latency.
    step(0, 0, 1, 12'h010, 32'hDEADBEEF, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0, 1, 0, 12'h010, '0);
    idle(4);

    // CPU stores every cycle for 50 cycles while a read waits.
    step(0, 0, 0, '0, '0, 1, 0, 12'h020, '0);
    for (int i = 0; i < 50; i++) step(0, 0, 1, 12'h020, 32'h1000 + i, 0, 0, '0, '0);
    idle(3);
    step(0, 1, 0, 12'h020, '0, 0, 0, '0, '0);
    idle(1);
`ifdef DMEM_ARB_STATS_EN
    @(negedge clock);
    chk("stat_grants", 64'(stat_grants), 64'd2);
    chk("stat_stall_cycles", 64'(stat_stall_cycles), 64'd50);
`endif

    // Write then read back through the peripheral port.
    step(0, 0, 0, '0, '0, 1, 1, 12'h0FF, 32'h55);
    idle(3);
    step(0, 0, 0, '0, '0, 1, 0, 12'h0FF, '0);
    idle(3);

    // Reset while a write is pending, on a cycle the slot would be free.
    step(0, 0, 0, '0, '0, 1, 1, 12'h123, 32'hAA);
    step(0, 0, 1, 12'h200, 32'h7, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge clock);
    chk("reset_no_ram_write", {63'd0, ram_wen}, 64'd0);
    idle(2);
    step(0, 1, 0, 12'h123, '0, 0, 0, '0, '0);
    idle(2);

    // Randomised traffic on a small address window to force collisions.
    have = 0;
    for (int n = 0; n < 600; n++) begin
      if (!have && $urandom_range(0, 2) == 0) begin
        have = 1; hwe = $urandom_range(0, 1) == 1;
        ha = AW'($urandom_range(0, 15)); hd = $urandom;
      end
      r = $urandom_range(0, 9);
      step(0, r < 3, (r >= 3) && (r < 6), AW'($urandom_range(0, 15)), $urandom,
           have, hwe, ha, hd);
      if (accepted) have = 0;
    end
    idle(4);
`ifdef DMEM_ARB_STATS_EN
    @(negedge clock);
    chk("stat_grants_end", 64'(stat_grants), 64'(m_grants));
    chk("stat_stall_end", 64'(stat_stall_cycles), 64'(m_stalls));
`endif
    @(negedge clock);
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
